// File: rtl/hc_periph_pkg.sv
// Shared definitions for the HC165/HC595 AHB-Lite peripherals: bus encodings,
// register word offsets, scan FSM states and byte-lane helpers.
package hc_periph_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;

  localparam logic [13:0] REG_RAW    = 14'd0;
  localparam logic [13:0] REG_STABLE = 14'd1;
  localparam logic [13:0] REG_EDGE   = 14'd2;
  localparam logic [13:0] REG_IRQ_EN = 14'd3;

  typedef enum logic [1:0] {S_LOAD, S_SAMPLE, S_CLK, S_DONE} scan_state_e;

  function automatic logic [3:0] ahb_strobe(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/ahb_hc165_keyin_if.sv
// AHB-Lite slave-side signal bundle for the HC165 key-input peripheral.
interface ahb_hc165_keyin_if;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_lite_regif.sv
// AHB-Lite zero-wait front end: captures the address phase and presents
// word address, read/write enables and byte strobes during the data phase.
module ahb_lite_regif
  import hc_periph_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsel,
  input  logic [15:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic [2:0]  i_hsize,
  input  logic        i_hwrite,
  input  logic        i_hready,
  output logic [13:0] o_word_addr,
  output logic        o_read_en,
  output logic        o_write_en,
  output logic [3:0]  o_byte_strobe
);

  logic        w_req;
  logic        r_rd;
  logic        r_wr;
  logic [13:0] r_addr;
  logic [3:0]  r_strb;

  assign w_req = i_hsel & i_hready & ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_strb <= '0;
    end else if (i_hready) begin
      r_rd   <= w_req & ~i_hwrite;
      r_wr   <= w_req & i_hwrite;
      r_addr <= i_haddr[15:2];
      r_strb <= ahb_strobe(i_hsize, i_haddr[1:0]);
    end
  end

  assign o_word_addr   = r_addr;
  assign o_read_en     = r_rd;
  assign o_write_en    = r_wr;
  assign o_byte_strobe = r_strb;

endmodule

// File: rtl/ahb_hc165_keyin.sv
// AHB-Lite slave scanning a cascaded 74HC165 chain; exposes raw, debounced and
// edge-latched inputs plus a maskable registered interrupt.
module ahb_hc165_keyin
  import hc_periph_pkg::*;
#(
  parameter int HC165_DRV_CLK_DIV = 49,
  parameter int CHAIN_BITS        = 16,
  parameter int DEBOUNCE_SCANS    = 4
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahb_hc165_keyin_if.slave   bus,
  output logic               PL_N,
  output logic               CP,
  input  logic               Q7,
  output logic               IRQ
);

  localparam int DIV_W = (HC165_DRV_CLK_DIV < 1) ? 1 : $clog2(HC165_DRV_CLK_DIV + 1);
  localparam int CNT_W = 6;
  localparam logic [31:0] CHAIN_MASK = 32'((64'd1 << CHAIN_BITS) - 64'd1);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  logic [13:0]            w_word_addr;
  logic                   w_read_en;
  logic                   w_write_en;
  logic [3:0]             w_strb;
  logic [31:0]            w_wmask;
  logic                   w_tick;
  logic [DIV_W-1:0]       r_div;
  scan_state_e            r_state;
  scan_state_e            w_state_nxt;
  logic                   r_pl_n;
  logic                   r_cp;
  logic                   w_pl_n_nxt;
  logic                   w_cp_nxt;
  logic [CHAIN_BITS-1:0]  r_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [CHAIN_BITS-1:0]  r_raw;
  logic [CHAIN_BITS-1:0]  r_stable;
  logic [3:0]             r_dbc_cnt;
  logic [3:0]             w_dbc_nxt;
  logic                   w_scan_done;
  logic                   w_dbc_take;
  logic [31:0]            w_edge_set;
  logic [31:0]            w_edge_clr;
  logic [31:0]            r_edge;
  logic [31:0]            r_irq_en;
  logic                   r_irq;

  ahb_lite_regif u_regif (
    .i_clk         (HCLK),
    .i_rst         (HRESET),
    .i_hsel        (bus.HSEL),
    .i_haddr       (bus.HADDR),
    .i_htrans      (bus.HTRANS),
    .i_hsize       (bus.HSIZE),
    .i_hwrite      (bus.HWRITE),
    .i_hready      (bus.HREADY),
    .o_word_addr   (w_word_addr),
    .o_read_en     (w_read_en),
    .o_write_en    (w_write_en),
    .o_byte_strobe (w_strb)
  );

  assign w_tick = (r_div == DIV_W'(HC165_DRV_CLK_DIV));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_div <= '0;
    else        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
  end

  // Scan FSM: strobe outputs are registered so the chain never sees a derived clock
  always_comb begin
    w_state_nxt = r_state;
    w_pl_n_nxt  = r_pl_n;
    w_cp_nxt    = r_cp;
    if (w_tick) begin
      case (r_state)
        S_LOAD: begin
          w_pl_n_nxt  = 1'b0;
          w_cp_nxt    = 1'b0;
          w_state_nxt = S_SAMPLE;
        end
        S_SAMPLE: begin
          w_pl_n_nxt  = 1'b1;
          w_cp_nxt    = 1'b0;
          w_state_nxt = (r_bit_cnt == CNT_W'(CHAIN_BITS - 1)) ? S_DONE : S_CLK;
        end
        S_CLK: begin
          w_cp_nxt    = 1'b1;
          w_state_nxt = S_SAMPLE;
        end
        default: w_state_nxt = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_LOAD;
      r_pl_n  <= 1'b1;
      r_cp    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pl_n  <= w_pl_n_nxt;
      r_cp    <= w_cp_nxt;
    end
  end

  assign w_scan_done = w_tick && (r_state == S_DONE);
  assign w_dbc_nxt   = (r_shreg == r_raw) ? sat_inc(r_dbc_cnt) : 4'd1;
  assign w_dbc_take  = w_scan_done && (w_dbc_nxt >= 4'(DEBOUNCE_SCANS)) && (r_shreg != r_stable);
  assign w_edge_set  = w_dbc_take ? 32'(r_shreg ^ r_stable) : 32'd0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_raw     <= '0;
      r_stable  <= '0;
      r_dbc_cnt <= '0;
    end else if (w_tick) begin
      if (r_state == S_SAMPLE) begin
        r_shreg   <= {r_shreg[CHAIN_BITS-2:0], Q7};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end else if (r_state == S_DONE) begin
        r_raw     <= r_shreg;
        r_dbc_cnt <= w_dbc_nxt;
        r_bit_cnt <= '0;
        if (w_dbc_take) r_stable <= r_shreg;
      end
    end
  end

  // Register file: a debounce set on EDGE overrides a same-cycle W1C clear
  assign w_wmask    = strobe_mask(w_strb);
  assign w_edge_clr = (w_write_en && (w_word_addr == REG_EDGE)) ? (bus.HWDATA & w_wmask) : 32'd0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_edge   <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_edge <= ((r_edge & ~w_edge_clr) | w_edge_set) & CHAIN_MASK;
      if (w_write_en && (w_word_addr == REG_IRQ_EN))
        r_irq_en <= ((r_irq_en & ~w_wmask) | (bus.HWDATA & w_wmask)) & CHAIN_MASK;
      r_irq <= |(r_edge & r_irq_en);
    end
  end

  always_comb begin
    bus.HRDATA = '0;
    if (w_read_en) begin
      case (w_word_addr)
        REG_RAW:    bus.HRDATA = 32'(r_raw);
        REG_STABLE: bus.HRDATA = 32'(r_stable);
        REG_EDGE:   bus.HRDATA = r_edge;
        REG_IRQ_EN: bus.HRDATA = r_irq_en;
        default:    bus.HRDATA = '0;
      endcase
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign PL_N          = r_pl_n;
  assign CP            = r_cp;
  assign IRQ           = r_irq;

endmodule
